// File: rtl/vx_fpu_req_pkg.sv
// Shared types for the FPU request arbiter: request payload layout and the
// round-robin index helper used by the grant search.
package vx_fpu_req_pkg;

    localparam int NUM_THREADS   = 4;
    localparam int NUM_LANES     = NUM_THREADS;
    localparam int UUID_WIDTH    = 44;
    localparam int NW_WIDTH      = 2;
    localparam int INST_FPU_BITS = 4;
    localparam int INST_FMT_BITS = 3;
    localparam int NR_BITS       = 5;

    typedef struct packed {
        logic [UUID_WIDTH-1:0]          uuid;
        logic [NW_WIDTH-1:0]            wid;
        logic [NUM_LANES-1:0]           tmask;
        logic [31:0]                    pc;
        logic [INST_FPU_BITS-1:0]       op_type;
        logic [INST_FMT_BITS-1:0]       op_mod;
        logic [NUM_LANES-1:0][31:0]     rs1_data;
        logic [NUM_LANES-1:0][31:0]     rs2_data;
        logic [NUM_LANES-1:0][31:0]     rs3_data;
        logic [NR_BITS-1:0]             rd;
        logic                           wb;
    } fpu_req_t;

    localparam int FPU_REQ_BITS = $bits(fpu_req_t);

    // Next index after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vx_fpu_req_fifo.sv
// Single-channel elastic buffer: power-of-two ring with wrap-around pointers
// and an explicit occupancy counter.
module vx_fpu_req_fifo
    import vx_fpu_req_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  fpu_req_t                 data_i,
    input  logic                     pop_i,
    output fpu_req_t                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FPU_REQ_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [CW-1:0]           count_q;

    // NOTE: storage is deliberately not reset; occupancy alone defines what
    // is valid, and leaving the array reset-free keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = fpu_req_t'(mem_q[rd_ptr_q]);
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/vx_fpu_req_arb.sv
// Merges NUM_REQS buffered FPU request channels into one registered stream
// with round-robin grant, source tagging and zero-tmask drop.
module vx_fpu_req_arb
    import vx_fpu_req_pkg::*;
#(
    parameter int NUM_REQS     = 2,
    parameter int BUF_DEPTH    = 2,
    parameter int REQ_IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  fpu_req_t [NUM_REQS-1:0]   in_req,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      out_valid,
    output fpu_req_t                  out_req,
    output logic [REQ_IDX_BITS-1:0]   out_idx,
    input  logic                      out_ready,
    output logic [NUM_REQS-1:0]       drop_pulse
);

    localparam int IDX_SPAN = 1 << REQ_IDX_BITS;
    localparam int CNT_BITS = $clog2(BUF_DEPTH) + 1;

    logic [NUM_REQS-1:0]     full_w;
    logic [NUM_REQS-1:0]     push_w;
    logic [NUM_REQS-1:0]     pop_w;
    logic [IDX_SPAN-1:0]     empty_pad;
    fpu_req_t                head_w [IDX_SPAN];
    logic [CNT_BITS-1:0]     count_w [NUM_REQS];
    logic [NUM_REQS-1:0]     unused_count_parity;

    logic                    slot_free;
    logic                    grant_fire;
    logic [REQ_IDX_BITS-1:0] grant_idx;

    logic [REQ_IDX_BITS-1:0] rr_ptr_q,    rr_ptr_d;
    logic                    out_valid_q, out_valid_d;
    fpu_req_t                out_req_q,   out_req_d;
    logic [REQ_IDX_BITS-1:0] out_idx_q,   out_idx_d;
    logic [NUM_REQS-1:0]     drop_q,      drop_d;

    assign in_ready = ~full_w & {NUM_REQS{~reset}};
    assign push_w   = in_valid & in_ready;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_chan
        vx_fpu_req_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push_w[i]),
            .data_i  (in_req[i]),
            .pop_i   (pop_w[i]),
            .head_o  (head_w[i]),
            .full_o  (full_w[i]),
            .empty_o (empty_pad[i]),
            .count_o (count_w[i])
        );
        assign pop_w[i] = grant_fire && (grant_idx == REQ_IDX_BITS'(i));
        assign unused_count_parity[i] = ^count_w[i];
    end

    // Unpopulated tag codes look like permanently empty channels.
    for (genvar i = NUM_REQS; i < IDX_SPAN; i++) begin : g_pad
        assign head_w[i]    = '0;
        assign empty_pad[i] = 1'b1;
    end

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        int unsigned cand;
        logic        found;
        slot_free = !out_valid_q || out_ready;
        found     = 1'b0;
        grant_idx = '0;
        cand      = 32'(rr_ptr_q);
        for (int k = 0; k < NUM_REQS; k++) begin
            if (!found && !empty_pad[cand[REQ_IDX_BITS-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[REQ_IDX_BITS-1:0];
            end
            cand = rr_next(cand, NUM_REQS);
        end
        grant_fire = slot_free && found;

        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_req_d   = out_req_q;
        out_idx_d   = out_idx_q;
        drop_d      = '0;
        if (slot_free) begin
            out_valid_d = 1'b0;
            if (found) begin
                rr_ptr_d = REQ_IDX_BITS'(rr_next(32'(grant_idx), NUM_REQS));
                if (head_w[grant_idx].tmask != '0) begin
                    out_valid_d = 1'b1;
                    out_req_d   = head_w[grant_idx];
                    out_idx_d   = grant_idx;
                end else begin
                    // Empty-mask request: consume the grant, report, emit nothing.
                    for (int i = 0; i < NUM_REQS; i++) begin
                        drop_d[i] = (32'(grant_idx) == i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_req_q   <= '0;
            out_idx_q   <= '0;
            drop_q      <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_req_q   <= out_req_d;
            out_idx_q   <= out_idx_d;
            drop_q      <= drop_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_req    = out_req_q;
    assign out_idx    = out_idx_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_vx_fpu_req_arb.sv
// Scoreboard bench for vx_fpu_req_arb: stimulus queues expected outputs and
// drops, a negedge monitor retires them as the DUT presents them.
module tb_vx_fpu_req_arb;
    import vx_fpu_req_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 2;

    logic                clk;
    logic                reset;
    logic [NR-1:0]       in_valid;
    fpu_req_t [NR-1:0]   in_req;
    logic [NR-1:0]       in_ready;
    logic                out_valid;
    fpu_req_t            out_req;
    logic [0:0]          out_idx;
    logic                out_ready;
    logic [NR-1:0]       drop_pulse;

    typedef struct {
        logic       is_drop;
        logic [0:0] idx;
        fpu_req_t   req;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    vx_fpu_req_arb #(.NUM_REQS(NR), .BUF_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_req     (in_req),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_req    (out_req),
        .out_idx    (out_idx),
        .out_ready  (out_ready),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic fpu_req_t mk(input logic [43:0] uuid, input logic [3:0] tmask);
        fpu_req_t r;
        r         = '0;
        r.uuid    = uuid;
        r.wid     = uuid[1:0];
        r.tmask   = tmask;
        r.pc      = 32'h8000_0000 + 32'(uuid);
        r.op_type = uuid[3:0];
        r.op_mod  = uuid[6:4];
        for (int l = 0; l < NUM_LANES; l++) begin
            r.rs1_data[l] = 32'(uuid) + 32'(l);
            r.rs2_data[l] = ~(32'(uuid) + 32'(l));
            r.rs3_data[l] = {16'(l), uuid[15:0]};
        end
        r.rd = uuid[4:0];
        r.wb = 1'b1;
        return r;
    endfunction

    function automatic exp_t exp_out(input logic [0:0] idx, input fpu_req_t req);
        exp_t e;
        e.is_drop = 1'b0;
        e.idx     = idx;
        e.req     = req;
        return e;
    endfunction

    function automatic exp_t exp_drop(input logic [0:0] idx);
        exp_t e;
        e.is_drop = 1'b1;
        e.idx     = idx;
        e.req     = '0;
        return e;
    endfunction

    // Monitor: retire one scoreboard entry per presented output or drop.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (drop_pulse != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_drop: got drop_pulse 0x%0h expected none", drop_pulse);
                end else begin
                    e = sb.pop_front();
                    check("mon_drop_kind", 64'(e.is_drop), 64'd1);
                    check("mon_drop_chan", 64'(drop_pulse), 64'(2'b01 << e.idx));
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected_out: got uuid 0x%0h idx %0d expected none", out_req.uuid, out_idx);
                end else begin
                    e = sb.pop_front();
                    check("mon_out_kind", 64'(e.is_drop), 64'd0);
                    check("mon_out_idx", 64'(out_idx), 64'(e.idx));
                    check("mon_out_uuid", 64'(out_req.uuid), 64'(e.req.uuid));
                    checks++;
                    if (out_req !== e.req) begin
                        errors++;
                        $display("FAIL mon_payload: got %h expected %h", out_req, e.req);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check({"drain_", name}, 64'(sb.size()), 64'd0);
    endtask

    int rr_win     = 0;
    bit rr_started = 1'b0;

    task automatic rr_sample();
        if (out_valid) rr_started = 1'b1;
        if (rr_started && rr_win < 8) begin
            rr_win++;
            check($sformatf("rr_busy_%0d", rr_win), 64'(out_valid), 64'd1);
        end
    endtask

    initial begin
        int            sent [NR];
        int            cyc;
        logic [NR-1:0] acc;

        reset     = 1'b1;
        in_valid  = '0;
        in_req    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_drop", 64'(drop_pulse), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_uuid", 64'(out_req.uuid), 64'd0);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd3);

        // Single request on channel 1: one cycle to output, then idle.
        in_req[1] = mk(44'h5, 4'hF);
        in_valid  = 2'b10;
        sb.push_back(exp_out(1'b1, mk(44'h5, 4'hF)));
        tick();
        in_valid = '0;
        check("t1_no_bypass", 64'(out_valid), 64'd0);
        tick();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_idx", 64'(out_idx), 64'd1);
        check("t1_uuid", 64'(out_req.uuid), 64'h5);
        tick();
        check("t1_idle", 64'(out_valid), 64'd0);
        wait_drain("single");

        // Round-robin: both channels stream 4 requests each; grants alternate.
        for (int k = 0; k < 4; k++) begin
            for (int ch = 0; ch < NR; ch++) begin
                sb.push_back(exp_out(1'(ch), mk(44'(32'h100 + 32'(ch) * 16 + 32'(k)), 4'hF)));
            end
        end
        sent[0] = 0;
        sent[1] = 0;
        cyc     = 0;
        while ((sent[0] < 4 || sent[1] < 4) && cyc < 50) begin
            for (int ch = 0; ch < NR; ch++) begin
                in_valid[ch] = (sent[ch] < 4);
                in_req[ch]   = mk(44'(32'h100 + 32'(ch) * 16 + 32'(sent[ch])), 4'hF);
            end
            acc = in_valid & in_ready;
            tick();
            cyc++;
            rr_sample();
            for (int ch = 0; ch < NR; ch++) begin
                if (acc[ch]) sent[ch]++;
            end
        end
        in_valid = '0;
        while (rr_win < 8 && cyc < 80) begin
            tick();
            cyc++;
            rr_sample();
        end
        check("rr_window", 64'(rr_win), 64'd8);
        wait_drain("rr");

        // Backpressure: output held, channel 0 fills, ready returns a cycle later.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) sb.push_back(exp_out(1'b0, mk(44'(32'h200 + 32'(k)), 4'hF)));
        check("bp_ready_initial", 64'(in_ready[0]), 64'd1);
        in_valid  = 2'b01;
        in_req[0] = mk(44'h200, 4'hF);
        tick();
        in_req[0] = mk(44'h201, 4'hF);
        tick();
        check("bp_out_valid", 64'(out_valid), 64'd1);
        check("bp_out_a", 64'(out_req.uuid), 64'h200);
        in_req[0] = mk(44'h202, 4'hF);
        tick();
        check("bp_full", 64'(in_ready[0]), 64'd0);
        in_req[0] = mk(44'h203, 4'hF);
        repeat (3) begin
            tick();
            check("bp_hold_uuid", 64'(out_req.uuid), 64'h200);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_notready", 64'(in_ready[0]), 64'd0);
        end
        out_ready = 1'b1;
        in_valid  = '0;
        #1;
        check("bp_no_comb_ready", 64'(in_ready[0]), 64'd0);
        tick();
        check("bp_ready_back", 64'(in_ready[0]), 64'd1);
        wait_drain("bp");

        // Drop: zero-mask request pulses drop, the next request follows a cycle later.
        sb.push_back(exp_drop(1'b0));
        sb.push_back(exp_out(1'b0, mk(44'h301, 4'hF)));
        in_valid  = 2'b01;
        in_req[0] = mk(44'h300, 4'h0);
        tick();
        in_req[0] = mk(44'h301, 4'hF);
        tick();
        in_valid = '0;
        check("drop_pulse_on", 64'(drop_pulse), 64'd1);
        check("drop_no_valid", 64'(out_valid), 64'd0);
        tick();
        check("drop_pulse_off", 64'(drop_pulse), 64'd0);
        check("drop_next_valid", 64'(out_valid), 64'd1);
        check("drop_next_uuid", 64'(out_req.uuid), 64'h301);
        wait_drain("drop");

        // Asynchronous reset with three requests buffered and one on the output.
        out_ready = 1'b0;
        in_valid  = 2'b11;
        in_req[0] = mk(44'h400, 4'hF);
        in_req[1] = mk(44'h410, 4'hF);
        tick();
        in_req[0] = mk(44'h401, 4'hF);
        in_req[1] = mk(44'h411, 4'hF);
        tick();
        in_valid = '0;
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_ready", 64'(in_ready), 64'd0);
        check("rst_async_drop", 64'(drop_pulse), 64'd0);
        tick();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_rel_ready", 64'(in_ready), 64'd3);
        repeat (5) begin
            tick();
            check("rst_no_stale", 64'(out_valid), 64'd0);
        end
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_fpu_req_arb.md
# vx_fpu_req_arb

Parametrised successor to the single-channel FPU request interface: merges `NUM_REQS` independent FPU request channels into one FPU request stream. Each channel has its own elastic buffer of `BUF_DEPTH` entries; a round-robin arbiter selects among non-empty buffers into a registered output stage that drives the FPU request port. It sits between the per-warp-group issue slices and the shared FPU unit, and adds source tagging plus drop of empty-mask requests.

## Interface
Parameters:
- `NUM_REQS`, 2: number of input channels, ≥1.
- `NUM_LANES`, `NUM_THREADS`: lanes per request.
- `BUF_DEPTH`, 2: per-channel buffer entries, power of two, ≥2.
- `REQ_IDX_BITS`, `$clog2(NUM_REQS)` (min 1): width of the source tag.

Ports (`fpu_req_t` is the packed request payload: uuid, wid, tmask[NUM_LANES], PC[32], op_type, op_mod, rs1/rs2/rs3_data[NUM_LANES][32], rd, wb):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  NUM_REQS  per-channel request valid.
- `in_req`  in  NUM_REQS × fpu_req_t  per-channel payload.
- `in_ready`  out  NUM_REQS  per-channel accept.
- `out_valid`  out  1  merged request valid.
- `out_req`  out  fpu_req_t  merged payload.
- `out_idx`  out  REQ_IDX_BITS  source channel of `out_req`.
- `out_ready`  in  1  FPU accept.
- `drop_pulse`  out  NUM_REQS  one-cycle pulse when a zero-tmask request from that channel is discarded.

## Operation
- Channel push: `in_valid[i] && in_ready[i]` writes `in_req[i]` at the buffer tail. `in_ready[i] = !full[i] && !reset`; it depends only on buffer state, with no combinational path from `out_ready`.
- Full buffer: no push in the same cycle as a pop. A full channel stays not-ready until the cycle after an entry leaves.
- Output slot free: `!out_valid || out_ready`.
- Arbitration runs only when the output slot is free. Candidates are the non-empty buffers. Search starts at `rr_ptr` and wraps modulo `NUM_REQS`.
- On a grant to channel g:
  - Pop the head of g and set `rr_ptr <= (g+1) mod NUM_REQS`.
  - If the head tmask is nonzero, load `out_req`/`out_idx` and set `out_valid = 1`.
  - If the head tmask is zero, discard the entry, assert `drop_pulse[g]` for one cycle, and leave `out_valid` at 0. A drop still consumes the grant slot for that cycle.
- No candidate while the slot is free: `out_valid <= 0`.
- Output stability: while `out_valid && !out_ready`, `out_req` and `out_idx` hold and there is no arbitration.
- Buffers use wrap-around read/write pointers of `$clog2(BUF_DEPTH)` bits plus an occupancy counter of `$clog2(BUF_DEPTH)+1` bits. Push-only increments, pop-only decrements, push and pop together leave it unchanged.
- Reset, at any time including mid-transfer: all buffers empty, pointers 0, `rr_ptr = 0`, `out_valid = 0`, `out_req`/`out_idx = 0`, `drop_pulse = 0`, `in_ready = 0` while asserted. Buffered requests are lost; upstream re-issues them.

## Timing
- Latency: push in cycle N, empty buffer, free slot → `out_valid` in cycle N+1. There is no same-cycle bypass.
- Throughput: one request per cycle sustained with `out_ready = 1`. A single channel alone also sustains one per cycle once `BUF_DEPTH ≥ 2`.
- Fairness: with all channels continuously non-empty, each channel is granted once every `NUM_REQS` grants.
- `drop_pulse` is registered and asserted in the cycle after the grant, aligned with when `out_valid` would have risen.
- All outputs come from flops except `in_ready`, which is a decode of registered state plus `reset`.

## Structure
- Package `vx_fpu_req_pkg` holds:
  - `fpu_req_t` packed struct.
  - `localparam FPU_REQ_BITS = $bits(fpu_req_t)`.
  - A `rr_next` function (index wrap helper).
- Sub-module `vx_fpu_req_fifo`: a single-channel buffer (push/pop, full/empty, head, count), instantiated `NUM_REQS` times in a generate loop.
- The arbiter and output register are inline in the top module.

## Test plan
- Single request: `NUM_REQS=2`, channel 1 pushes uuid=0x5 in cycle 3 with `out_ready=1` → `out_valid=1`, `out_idx=1`, `out_req.uuid=0x5` in cycle 4, and `out_valid=0` in cycle 5.
- Round-robin: both channels push 4 requests back-to-back with `out_ready=1` → `out_idx` sequence 0,1,0,1,0,1,0,1, with no idle cycle after the first.
- Backpressure: `out_ready=0` for 6 cycles while channel 0 pushes continuously → `out_req` stable. `in_ready[0]` falls after 2 accepts buffered (`BUF_DEPTH=2`) plus 1 held in the output register. It rises 1 cycle after `out_ready` returns.
- Drop: channel 0 pushes tmask=0 and then tmask=0xF → `drop_pulse[0]` for one cycle. Only the 0xF request appears on the output, one cycle after the drop pulse.
- Reset mid-operation: assert `reset` asynchronously with 3 requests buffered and `out_valid=1` → `out_valid=0` and `in_ready=0` immediately. After release, `in_ready` returns to all-ones and no stale request emerges.
